multiplier_pipe: RTL and testbench

MULTIPLIER_PIPE -- requirements
Module: multiplier_pipe

---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult_pipe_stage.sv | 37 +++
 rtl/multiplier_pipe.sv | 147 ++++++++++++++
 tb/tb_multiplier_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier_pipe slice: parameter ranges, operand mode
// and the default stage payload layout (sized for the widest legal configuration).
package mult_pkg;

  localparam int unsigned W_MIN      = 4;
  localparam int unsigned W_MAX      = 32;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;
  localparam int unsigned TAG_W_MIN  = 1;
  localparam int unsigned TAG_W_MAX  = 16;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  // Product kept in carry-save form (sum + carry) until the last stage.
  typedef struct packed {
    logic [TAG_W_MAX-1:0] tag;
    mode_e                mode;
    logic [2*W_MAX-1:0]   sum;
    logic [2*W_MAX-1:0]   carry;
  } stage_payload_t;

endpackage

// File: rtl/mult_pipe_stage.sv
// One valid/enable register slice of the multiplier pipeline; loads whenever it is
// empty or its contents are being taken by the next slice.
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter type payload_t = stage_payload_t
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_valid,
  input  payload_t i_data,
  input  logic     i_next_ready,
  output logic     o_valid,
  output logic     o_ready,
  output payload_t o_data
);

  logic     r_valid;
  payload_t r_data;

  assign o_ready = !r_valid || i_next_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined signed/unsigned W x W multiplier with valid/ready flow control and tag sideband.
// Define MULTIPLIER_PIPE_STATS_EN to build the cnt_done/cnt_stall statistics counters.
module multiplier_pipe
  import mult_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      cnt_done,
  output logic [31:0]      cnt_stall
);

  localparam int unsigned PW = 2 * W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    mode_e            mode;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    carry;
  } payload_t;

  logic     w_valid [STAGES];
  logic     w_ready [STAGES];
  payload_t w_q     [STAGES];

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;
  logic [PW-1:0] w_pp_lo;
  logic [PW-1:0] w_pp_hi;

  // Extending both operands to 2W bits makes the modulo-2^(2W) row sum correct for both modes.
  always_comb begin
    w_a_ext = in_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    w_b_ext = in_signed ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    w_pp_lo = '0;
    w_pp_hi = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (i < W) begin
        w_pp_lo = w_pp_lo + ({PW{w_b_ext[i]}} & (w_a_ext << i));
      end else begin
        w_pp_hi = w_pp_hi + ({PW{w_b_ext[i]}} & (w_a_ext << i));
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    payload_t w_d;
    logic     w_load_valid;
    logic     w_next_ready;

    if (k == 0) begin : g_first
      always_comb begin
        w_d       = '0;
        w_d.tag   = in_tag;
        w_d.mode  = mode_e'(in_signed);
        if (STAGES == 1) begin
          w_d.sum = w_pp_lo + w_pp_hi;
        end else begin
          w_d.sum   = w_pp_lo;
          w_d.carry = w_pp_hi;
        end
      end
      assign w_load_valid = in_valid;
    end else if (k == STAGES - 1) begin : g_last
      always_comb begin
        w_d      = '0;
        w_d.tag  = w_q[k-1].tag;
        w_d.mode = w_q[k-1].mode;
        w_d.sum  = w_q[k-1].sum + w_q[k-1].carry;
      end
      assign w_load_valid = w_valid[k-1];
    end else begin : g_mid
      // Half-adder compression: s + c == (s ^ c) + ((s & c) << 1).
      always_comb begin
        w_d       = '0;
        w_d.tag   = w_q[k-1].tag;
        w_d.mode  = w_q[k-1].mode;
        w_d.sum   = w_q[k-1].sum ^ w_q[k-1].carry;
        w_d.carry = (w_q[k-1].sum & w_q[k-1].carry) << 1;
      end
      assign w_load_valid = w_valid[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign w_next_ready = out_ready;
    end else begin : g_body
      assign w_next_ready = w_ready[k+1];
    end

    mult_pipe_stage #(
      .payload_t(payload_t)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst),
      .i_valid     (w_load_valid),
      .i_data      (w_d),
      .i_next_ready(w_next_ready),
      .o_valid     (w_valid[k]),
      .o_ready     (w_ready[k]),
      .o_data      (w_q[k])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[STAGES-1];
  assign product   = w_q[STAGES-1].sum;
  assign out_tag   = w_q[STAGES-1].tag;

`ifdef MULTIPLIER_PIPE_STATS_EN
  logic [31:0] r_cnt_done;
  logic [31:0] r_cnt_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_done  <= '0;
      r_cnt_stall <= '0;
    end else begin
      if (out_valid && out_ready) begin
        r_cnt_done <= r_cnt_done + 32'd1;
      end
      if (out_valid && !out_ready) begin
        r_cnt_stall <= r_cnt_stall + 32'd1;
      end
    end
  end

  assign cnt_done  = r_cnt_done;
  assign cnt_stall = r_cnt_stall;
`else
  assign cnt_done  = '0;
  assign cnt_stall = '0;
`endif

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed self-checking bench for multiplier_pipe (W=8, STAGES=3, TAG_W=4).
module tb_multiplier_pipe;

  localparam bit STATS =
`ifdef MULTIPLIER_PIPE_STATS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [3:0]  out_tag;
  logic [31:0] cnt_done;
  logic [31:0] cnt_stall;

  multiplier_pipe #(.W(8), .STAGES(3), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .out_tag(out_tag), .cnt_done(cnt_done), .cnt_stall(cnt_stall)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] p; logic [3:0] t; } exp_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        sb[$];
  logic [7:0]  av [16];
  logic [7:0]  bv [16];
  logic        sv [16];
  int          nxt;
  int          n_total;
  int          n_rx;
  logic        prev_stall;
  logic [15:0] prev_prod;
  logic [3:0]  prev_tag;
  int          exp_done;
  int          exp_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int px;
    if (s) px = int'($signed(x)) * int'($signed(y));
    else   px = int'(x) * int'(y);
    return px[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string nm);
    chk({nm, "_cnt_done"},  cnt_done,  STATS ? exp_done  : 0);
    chk({nm, "_cnt_stall"}, cnt_stall, STATS ? exp_stall : 0);
  endtask

  // Single transaction with out_ready high: out_valid must appear on the third edge counting the transfer edge.
  task automatic run_one(input string nm, input logic [7:0] x, input logic [7:0] y,
                         input logic s, input logic [3:0] t, input logic [15:0] exp_p);
    a = x; b = y; in_signed = s; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({nm, "_lat1"}, out_valid, 0);
    tick();
    chk({nm, "_lat2"}, out_valid, 0);
    tick();
    chk({nm, "_valid"},   out_valid, 1);
    chk({nm, "_product"}, product, exp_p);
    chk({nm, "_tag"},     out_tag, t);
    tick();
    chk({nm, "_drained"}, out_valid, 0);
  endtask

  // One streaming cycle: drive, settle, score handshakes, then advance past the edge.
  task automatic step(input logic rdy, input logic feed, input int exp_ir, input string nm);
    exp_t e;
    out_ready = rdy;
    in_valid  = feed && (nxt < n_total);
    if (in_valid) begin
      a = av[nxt]; b = bv[nxt]; in_signed = sv[nxt]; in_tag = 4'(nxt);
    end
    #1;
    if (exp_ir >= 0) chk({nm, "_in_ready"}, in_ready, exp_ir[0]);
    if (prev_stall) begin
      chk({nm, "_hold_product"}, product, prev_prod);
      chk({nm, "_hold_tag"},     out_tag, prev_tag);
    end
    if (in_valid && in_ready) begin
      e.p = model(av[nxt], bv[nxt], sv[nxt]);
      e.t = 4'(nxt);
      sb.push_back(e);
      nxt++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk({nm, "_spurious_out"}, out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk({nm, "_product"}, product, e.p);
        chk({nm, "_tag"},     out_tag, e.t);
        n_rx++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_prod  = product;
    prev_tag   = out_tag;
    tick();
  endtask

  task automatic drain(input string nm, input int bound);
    int cyc = 0;
    while ((nxt < n_total || sb.size() > 0) && cyc < bound) begin
      step(1'b1, 1'b1, -1, nm);
      cyc++;
    end
    chk({nm, "_drain_left"}, 64'(sb.size()) + 64'(n_total - nxt), 0);
  endtask

  task automatic new_stream(input int n);
    n_total = n; nxt = 0; n_rx = 0; prev_stall = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; in_signed = 1'b0; in_tag = '0;
    exp_done = 0; exp_stall = 0;
    prev_stall = 1'b0; prev_prod = '0; prev_tag = '0;
    n_total = 0; nxt = 0; n_rx = 0;

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product",   product, 0);
    chk("rst_out_tag",   out_tag, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk_counters("rst");
    tick();
    tick();
    rst = 1'b1;

    // Test 1 and 2: first transfer right after release, plus signed/unsigned corners.
    run_one("t1_ff_ff_u",  8'hFF, 8'hFF, 1'b0, 4'd5, 16'hFE01);
    run_one("t2_80_80_s",  8'h80, 8'h80, 1'b1, 4'd1, 16'h4000);
    run_one("t2_ff_01_s",  8'hFF, 8'h01, 1'b1, 4'd2, 16'hFFFF);
    run_one("t2_ff_01_u",  8'hFF, 8'h01, 1'b0, 4'd3, 16'h00FF);
    run_one("t2_7f_80_s",  8'h7F, 8'h80, 1'b1, 4'd4, 16'hC080);
    exp_done = 5;
    chk_counters("t2");

    // Test 3: fill against a stalled output, then release.
    new_stream(8);
    for (int i = 0; i < 8; i++) begin
      av[i] = 8'(i + 1); bv[i] = 8'd3; sv[i] = 1'b0;
    end
    step(1'b0, 1'b1, 1, "t3_fill0");
    step(1'b0, 1'b1, 1, "t3_fill1");
    step(1'b0, 1'b1, 1, "t3_fill2");
    step(1'b0, 1'b1, 0, "t3_full0");
    step(1'b0, 1'b1, 0, "t3_full1");
    step(1'b0, 1'b1, 0, "t3_full2");
    chk("t3_accepted", nxt, 3);
    chk("t3_head_tag", out_tag, 0);
    exp_stall = 3;
    chk_counters("t3_stalled");
    drain("t3_release", 40);
    chk("t3_received", n_rx, 8);
    exp_done = 13;
    chk_counters("t3_end");

    // Test 4: full pipeline, continuous input, out_ready alternating 0/1.
    new_stream(16);
    for (int i = 0; i < 16; i++) begin
      av[i] = 8'(i * 53 + 8'h81);
      bv[i] = 8'(8'hF0 - i * 29);
      sv[i] = i[0];
    end
    step(1'b0, 1'b1, 1, "t4_fill0");
    step(1'b0, 1'b1, 1, "t4_fill1");
    step(1'b0, 1'b1, 1, "t4_fill2");
    for (int t = 0; t < 12; t++) begin
      step(t[0], 1'b1, -1, "t4_toggle");
    end
    drain("t4_drain", 60);
    chk("t4_received", n_rx, 16);
    exp_done  = 29;
    exp_stall = 9;
    chk_counters("t4_end");

    // Test 5: reset with two transactions in flight.
    new_stream(2);
    av[0] = 8'h11; bv[0] = 8'h22; sv[0] = 1'b0;
    av[1] = 8'h33; bv[1] = 8'h44; sv[1] = 1'b0;
    step(1'b1, 1'b1, 1, "t5_load0");
    step(1'b1, 1'b1, 1, "t5_load1");
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_product",   product, 0);
    chk("t5_rst_in_ready",  in_ready, 1);
    exp_done = 0; exp_stall = 0;
    chk_counters("t5_rst");
    tick();
    chk("t5_rst_hold_valid", out_valid, 0);
    rst = 1'b1;
    sb.delete();
    tick();
    chk("t5_idle0", out_valid, 0);
    tick();
    chk("t5_idle1", out_valid, 0);
    run_one("t5_after", 8'h12, 8'h34, 1'b0, 4'd9, 16'h03A8);
    exp_done = 1;
    chk_counters("t5_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
